// File: rtl/rf_sched_pkg.sv
// Shared constants for the register-file write-back scheduler: requester
// indices, register count and the hard-wired zero register.
package rf_sched_pkg;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LSU = 1;
    localparam int unsigned REQ_MDU = 2;
    localparam int unsigned NREG    = 32;
    localparam logic [4:0]  X0      = 5'd0;

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// NREQ-wide round-robin arbiter: the search starts at the pointer and wraps.
// The pointer moves one past the winner and holds when nothing is requested.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    localparam int unsigned PW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o,
    output logic            gnt_valid_o,
    output logic [PW-1:0]   gnt_idx_o
);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int idx;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = PW'(idx);
            end
        end
    end

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        if (gnt_valid_o) begin
            grant_o[gnt_idx_o] = 1'b1;
            ptr_d = (int'(gnt_idx_o) == int'(NREQ) - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Shares the register-file write port among NREQ write-back units and keeps
// a busy scoreboard of pending destinations to stall RAW/WAW issue hazards.
module rf_wb_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      wb_valid_i,
    output logic [NREQ-1:0]      wb_ready_o,
    input  logic [NREQ*AW-1:0]   wb_rd_i,
    input  logic [NREQ*XLEN-1:0] wb_data_i,
    input  logic                 iss_valid_i,
    input  logic                 iss_wr_i,
    input  logic [AW-1:0]        iss_rd_i,
    input  logic [AW-1:0]        iss_rs1_i,
    input  logic [AW-1:0]        iss_rs2_i,
    output logic                 iss_stall_o,
    output logic                 rf_we_o,
    output logic [AW-1:0]        rf_waddr_o,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic [NREG-1:0]      busy_vec_o
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [PW-1:0]   gnt_idx;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;

    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req_i      (wb_valid_i),
        .grant_o    (gnt),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx)
    );

    assign wb_ready_o = gnt & {NREQ{~rst}};

    always_comb begin
        gnt_rd   = '0;
        gnt_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                gnt_rd   = wb_rd_i[i*AW +: AW];
                gnt_data = wb_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // Address and data hold when idle so the last write stays visible.
    always_comb begin
        rf_we_d    = gnt_valid && (gnt_rd != AW'(X0));
        rf_waddr_d = gnt_valid ? gnt_rd   : rf_waddr_q;
        rf_wdata_d = gnt_valid ? gnt_data : rf_wdata_q;
    end

    // A source in flight on the write port this cycle is forwarded by the RF.
    function automatic logic pending(input logic [AW-1:0] r);
        return busy_q[r] && !(rf_we_q && rf_waddr_q == r);
    endfunction

    assign iss_stall_o = iss_valid_i &&
        (pending(iss_rs1_i) || pending(iss_rs2_i) ||
         (iss_wr_i && busy_q[iss_rd_i] && iss_rd_i != AW'(X0)));

    // Set is applied after clear so a newer producer keeps ownership.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
        if (iss_valid_i && iss_wr_i && iss_rd_i != AW'(X0) && !iss_stall_o)
            busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_vec_o = busy_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: arbitration, write-back timing,
// scoreboard hazards, x0 handling and asynchronous reset.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  wb_valid = '0;
    logic [2:0]  wb_ready;
    logic [14:0] wb_rd = '0;
    logic [95:0] wb_data = '0;
    logic        iss_valid = 1'b0, iss_wr = 1'b0;
    logic [4:0]  iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
    logic        iss_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, busy_vec;

    int errors = 0;
    int checks = 0;

    rf_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid), .wb_ready_o(wb_ready),
        .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .iss_valid_i(iss_valid), .iss_wr_i(iss_wr), .iss_rd_i(iss_rd),
        .iss_rs1_i(iss_rs1), .iss_rs2_i(iss_rs2), .iss_stall_o(iss_stall),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .busy_vec_o(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
        wb_rd[i*5 +: 5]    = rd;
        wb_data[i*32 +: 32] = d;
    endtask

    task automatic issue(input logic v, input logic wr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = v; iss_wr = wr; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
    endtask

    task automatic test_reset();
        wb_valid = 3'b111;
        #3;
        checks++; if (wb_ready !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b want 000", wb_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wb: got %h/%h want 0/0", rf_waddr, rf_wdata); end
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL rst_busy: got %h want 0", busy_vec); end
        wb_valid = 3'b000;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu_only();
        set_req(0, 5'd5, 32'hDEADBEEF);
        wb_valid = 3'b001;
        #1;
        checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL alu_ready: got %b want 001", wb_ready); end
        step();
        wb_valid = 3'b000;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wb: got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
        step();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_idle: got we=%b a=%0d d=%h want 0/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        // Grant the MDU once so the pointer wraps back to 0.
        set_req(2, 5'd20, 32'h0);
        wb_valid = 3'b100;
        step();
        for (int i = 0; i < 3; i++) set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
        wb_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_g = 3'b001 << (c % 3);
            #1;
            checks++; if (wb_ready !== exp_g) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", c, wb_ready, exp_g); end
            step();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'((c % 3) + 1) || rf_wdata !== 32'hA000_0000 + 32'(c % 3)) begin errors++; $display("FAIL rr_wb%0d: got a=%0d d=%h want a=%0d", c, rf_waddr, rf_wdata, (c % 3) + 1); end
        end
        wb_valid = 3'b000;
        step();
    endtask

    task automatic test_raw_forward();
        issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        #1;
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_first: got stall %b want 0", iss_stall); end
        step();
        checks++; if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL raw_set: got %h want 00000080", busy_vec); end
        issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
        set_req(1, 5'd7, 32'h0000_0077);
        wb_valid = 3'b010;
        #1;
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", iss_stall); end
        checks++; if (wb_ready !== 3'b010) begin errors++; $display("FAIL raw_lsu_ready: got %b want 010", wb_ready); end
        step();
        wb_valid = 3'b000;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++; $display("FAIL raw_wb: got we=%b a=%0d want 1/7", rf_we, rf_waddr); end
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_forward: got stall %b want 0", iss_stall); end
        step();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL raw_clear: got %h want 0", busy_vec); end
    endtask

    task automatic test_waw_set_wins();
        issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        step();
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL waw_set: got %h want 00000200", busy_vec); end
        set_req(2, 5'd9, 32'h0000_0999);
        wb_valid = 3'b100;
        #1;
        checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", iss_stall); end
        step();
        wb_valid = 3'b000;
        // The rd check has no forwarding exception.
        checks++; if (rf_we !== 1'b1 || iss_stall !== 1'b1) begin errors++; $display("FAIL waw_noforward: got we=%b stall=%b want 1/1", rf_we, iss_stall); end
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step();
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL waw_clear: got %h want 0", busy_vec); end
        // Write to non-busy x9 and a new producer of x9 on the committing edge.
        set_req(0, 5'd9, 32'h0000_1999);
        wb_valid = 3'b001;
        step();
        wb_valid = 3'b000;
        issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
        #1;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || iss_stall !== 1'b0) begin errors++; $display("FAIL setwins_pre: got we=%b a=%0d stall=%b want 1/9/0", rf_we, rf_waddr, iss_stall); end
        step();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL setwins: got %h want 00000200", busy_vec); end
    endtask

    task automatic test_x0();
        set_req(0, 5'd0, 32'h0000_1234);
        wb_valid = 3'b001;
        issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b want 001", wb_ready); end
        checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", iss_stall); end
        step();
        wb_valid = 3'b000;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b want 0", rf_we); end
        checks++; if (busy_vec !== 32'h0000_0200) begin errors++; $display("FAIL x0_busy: got %h want 00000200", busy_vec); end
        // Retire x9 so the scoreboard is empty again.
        set_req(0, 5'd9, 32'h0);
        wb_valid = 3'b001;
        step();
        wb_valid = 3'b000;
        step();
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL x0_retire: got %h want 0", busy_vec); end
    endtask

    task automatic test_async_reset();
        issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
        step();
        issue(1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
        set_req(0, 5'd3, 32'h0000_3333);
        wb_valid = 3'b001;
        step();
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        wb_valid = 3'b101;
        set_req(2, 5'd4, 32'h0000_4444);
        checks++; if (busy_vec !== 32'h0000_0480 || rf_we !== 1'b1) begin errors++; $display("FAIL ar_pre: got busy=%h we=%b want 00000480/1", busy_vec, rf_we); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || busy_vec !== 32'd0) begin errors++; $display("FAIL ar_clear: got we=%b busy=%h want 0/0", rf_we, busy_vec); end
        checks++; if (wb_ready !== 3'b000) begin errors++; $display("FAIL ar_ready: got %b want 000", wb_ready); end
        step();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ar_hold: got we=%b want 0", rf_we); end
        rst = 1'b0;
        #1;
        checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL ar_ptr: got %b want 001", wb_ready); end
        step();
        wb_valid = 3'b000;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin errors++; $display("FAIL ar_first_wb: got we=%b a=%0d want 1/3", rf_we, rf_waddr); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_round_robin();
        test_raw_forward();
        test_waw_set_wins();
        test_x0();
        test_async_reset();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the single register-file write port (we/waddr/wdata) among NREQ write-back requesters: ALU pipe, load unit, mul/div unit.
- Uses a valid/ready handshake and round-robin arbitration.
- Keeps a 32-entry busy scoreboard of pending destination registers and raises an issue stall on RAW/WAW hazards.
- Sits between the execute/memory units and the register file, next to the decode/issue stage.

Parameters:
- NREQ, 3, number of write-back requesters (index 0 = ALU, 1 = LSU, 2 = MDU); legal range 2..8.
- XLEN, 32, data width.
- AW, 5, register address width (32 registers, x0 hard-wired to zero).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  NREQ  requester i has a result.
- wb_ready  out  NREQ  requester i is accepted this cycle (one-hot or zero).
- wb_rd  in  NREQ*AW  packed destination addresses; slice i = bits [i*AW +: AW].
- wb_data  in  NREQ*XLEN  packed result data.
- iss_valid  in  1  decode is issuing an instruction this cycle (only when iss_stall=0).
- iss_wr  in  1  the issuing instruction writes rd.
- iss_rd, iss_rs1, iss_rs2  in  AW each  register fields of the issuing instruction.
- iss_stall  out  1  hazard: decode must hold.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- busy_vec  out  32  scoreboard state, for debug/verification.

Behaviour:
Reset:
- rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, round-robin pointer=0.
- wb_ready=0 while rst is high.

Arbitration (combinational):
- Grant goes to the first requester with wb_valid=1, searching from the pointer upward and wrapping at NREQ-1 -> 0.
- wb_ready is one-hot on the granted index; all-zero when no request is valid.
- wb_ready never depends on rf_we: the port accepts one result every cycle, no back-pressure beyond losing arbitration.
- Requesters hold wb_valid, wb_rd and wb_data stable until wb_ready is seen; a valid is never withdrawn before acceptance.
- Pointer update: on a grant to index g, pointer <= (g+1) mod NREQ; unchanged when there is no grant.

Write-back register stage (1-cycle latency):
- On the posedge after acceptance: rf_we <= (granted rd != 0), rf_waddr <= rd, rf_wdata <= data.
- With no grant: rf_we <= 0; rf_waddr and rf_wdata hold their values.
- Throughput is one write per cycle.

Scoreboard:
- Set: busy[iss_rd] <= 1 when iss_valid && iss_wr && iss_rd != 0 && !iss_stall.
- Clear: busy[rf_waddr] <= 0 at the edge where rf_we=1 (the write commits on that same edge).
- Simultaneous set and clear of the same register: set wins (the newer producer owns the register).
- busy[0] is always 0.

Hazard logic (combinational):
- A source is pending when busy[r]=1 and NOT (rf_we && rf_waddr==r); the register file forwards the in-flight write.
- iss_stall = iss_valid && ( pending(rs1) || pending(rs2) || (iss_wr && busy[iss_rd] && iss_rd != 0) ).
- The rd term stops WAW; it is checked against busy only, with no forwarding exception.
- rs = 0 never stalls.

Boundary cases:
- A write-back to a register that is not busy is still written; the scoreboard stays 0.
- All NREQ requesters valid continuously: each is granted exactly once every NREQ cycles.
- Asynchronous reset mid-operation: the in-flight write is dropped, the scoreboard clears, and no partial rf_we pulse appears.

Decomposition:
- Shared package rf_sched_pkg holds REQ_ALU=0, REQ_LSU=1, REQ_MDU=2, NREG=32 and the X0 address constant.
- One natural sub-module, rr_arbiter (NREQ-wide round-robin: req, grant, pointer register); the scoreboard and write-back register stay in the top.

Test Plan:
1. Reset, then ALU only: wb_valid=001, rd=5, data=0xDEADBEEF -> wb_ready=001 the same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the following cycle rf_we=0.
2. All three requesters valid for 6 cycles, pointer=0 -> grants 001,010,100,001,010,100; each requester holds until accepted; no grant is lost or duplicated.
3. Issue with rd=7 (busy[7]=1), then issue with rs1=7 -> iss_stall=1. Once LSU writes x7, iss_stall=0 in the cycle rf_we=1 and rf_waddr=7 (forward), and busy[7]=0 after that edge.
4. WAW and set-wins: busy[9]=1; issue with rd=9 -> stall. Then rf_we=1 to x9 while a new issue sets rd=9 on the same edge -> busy[9] stays 1.
5. Write-back with rd=0, data=0x1234 -> wb_ready asserted, rf_we stays 0, busy_vec unchanged; issue with rs1=0 and rs2=0 never stalls.
6. Assert rst asynchronously while rf_we=1 and busy_vec=0x0000_0480 -> immediately rf_we=0 and busy_vec=0; after release the pointer is 0 and the first grant goes to the lowest valid index.
